// File: rtl/dly_pkg.sv
// Shared types and constants for the programmable delay line.
// Holds the FILL/RUN state type, the default sizing and the delay-code clamp.
package dly_pkg;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_MAX_DLY = 16;
    localparam int DEF_RST_DLY = 4;

    // A zero delay cannot be honoured through a registered output, so it becomes 1.
    function automatic int unsigned clamp_dly(input int unsigned code, input int unsigned max_dly);
        if (code == 0) begin
            return 1;
        end
        if (code > max_dly) begin
            return max_dly;
        end
        return code;
    endfunction

endpackage

// File: rtl/dly_line_if.sv
// Sample/qualifier stream plus delay-load handshake of the delay line.
// The master drives samples and load requests; the slave is the delay line.
interface dly_line_if #(
    parameter int WIDTH = 8,
    parameter int DW    = 5
);
    logic [WIDTH-1:0] i;
    logic             i_vld;
    logic [DW-1:0]    dly;
    logic             dly_ld;
    logic             dly_ack;
    logic [WIDTH-1:0] z;
    logic             z_vld;
    logic             busy;
    logic [DW-1:0]    cur_dly;

    modport master (
        output i, i_vld, dly, dly_ld,
        input  dly_ack, z, z_vld, busy, cur_dly
    );

    modport slave (
        input  i, i_vld, dly, dly_ld,
        output dly_ack, z, z_vld, busy, cur_dly
    );
endinterface

// File: rtl/dly_ram.sv
// Circular sample store: one synchronous write port, one registered read port.
// The read register doubles as the delayed output and holds its data while idle.
module dly_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_vld,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_vld
);
    logic [WIDTH:0] mem [DEPTH];
    logic [WIDTH:0] rd_q_reg;

    always_ff @(posedge clk) begin
        mem[wr_addr] <= {wr_vld, wr_data};
    end

    // Separate block so a read of the word being written returns the old contents.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_q_reg <= '0;
        end else if (rd_en) begin
            rd_q_reg <= mem[rd_addr];
        end else begin
            rd_q_reg[WIDTH] <= 1'b0;
        end
    end

    assign rd_data = rd_q_reg[WIDTH-1:0];
    assign rd_vld  = rd_q_reg[WIDTH];
endmodule

// File: rtl/dly_line.sv
// Programmable free-running delay line with refill masking after reset or a delay load.
// Owns the FILL/RUN control, the write pointer and the read-address arithmetic.
module dly_line
    import dly_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MAX_DLY = DEF_MAX_DLY,
    parameter int RST_DLY = DEF_RST_DLY,
    localparam int DW     = $clog2(MAX_DLY + 1),
    localparam int AW     = $clog2(MAX_DLY)
) (
    input  logic     clk,
    input  logic     rstn,
    dly_line_if.slave bus
);
    state_t        state_reg;
    logic [DW-1:0] cur_dly_reg;
    logic [DW-1:0] fill_cnt_reg;
    logic [AW-1:0] wp_reg;
    logic [AW-1:0] wp_next;
    logic          dly_ack_reg;
    logic          busy_reg;
    logic [DW-1:0] ld_dly;
    logic [DW:0]   ra_sum;
    logic [DW:0]   ra_mod;
    logic [AW-1:0] rd_addr;
    logic          rd_en;

    assign ld_dly  = DW'(clamp_dly(32'(bus.dly), MAX_DLY));
    assign wp_next = (wp_reg == AW'(MAX_DLY - 1)) ? '0 : wp_reg + 1'b1;

    // Widened by one bit so wp + MAX_DLY - cur_dly never wraps before the modulo.
    always_comb begin
        ra_sum = (DW+1)'(wp_reg) + (DW+1)'(MAX_DLY) - {1'b0, cur_dly_reg};
        ra_mod = ra_sum;
        if (ra_sum >= (DW+1)'(MAX_DLY)) begin
            ra_mod = ra_sum - (DW+1)'(MAX_DLY);
        end
        rd_addr = AW'(ra_mod);
    end

    // Output freezes on the load edge itself so no old-delay sample slips out.
    assign rd_en = (state_reg == RUN) && !bus.dly_ld;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg    <= FILL;
            cur_dly_reg  <= DW'(RST_DLY);
            fill_cnt_reg <= '0;
            wp_reg       <= '0;
            dly_ack_reg  <= 1'b0;
            busy_reg     <= 1'b1;
        end else begin
            wp_reg      <= wp_next;
            dly_ack_reg <= bus.dly_ld;
            if (bus.dly_ld) begin
                cur_dly_reg  <= ld_dly;
                fill_cnt_reg <= '0;
                state_reg    <= FILL;
                busy_reg     <= 1'b1;
            end else if (state_reg == FILL) begin
                if (fill_cnt_reg == cur_dly_reg - DW'(1)) begin
                    state_reg <= RUN;
                    busy_reg  <= 1'b0;
                end else if (fill_cnt_reg != DW'(MAX_DLY)) begin
                    fill_cnt_reg <= fill_cnt_reg + 1'b1;
                end
            end
        end
    end

    dly_ram #(
        .WIDTH (WIDTH),
        .DEPTH (MAX_DLY)
    ) u_ram (
        .clk     (clk),
        .rstn    (rstn),
        .wr_addr (wp_reg),
        .wr_data (bus.i),
        .wr_vld  (bus.i_vld),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (bus.z),
        .rd_vld  (bus.z_vld)
    );

    assign bus.dly_ack = dly_ack_reg;
    assign bus.busy    = busy_reg;
    assign bus.cur_dly = cur_dly_reg;
endmodule
